// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount as 10/5/1 coins. Coins are chosen greedily, and only
// denominations with inventory left are used. The hopper is driven one coin at
// a time with a level eject/ack handshake.
//
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   dispense, change   one-cycle payout request and its amount
//   hop_ack            hopper has released the coin being ejected
//   refill             reload inventories (honoured only when idle)
//   eject10/5/1        level request for one coin of that value
//   busy, done         payout in progress / one-cycle completion pulse
//   shortfall          amount the last payout could not cover
//   overrun, fault     sticky: dispense while busy / hopper timeout
//   inv10/5/1          current coin inventory
module change_dispenser #(
  parameter int INV_W      = 8,
  parameter int INV_INIT10 = 20,
  parameter int INV_INIT5  = 20,
  parameter int INV_INIT1  = 50,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispense,
  input  logic [7:0]       change,
  input  logic             hop_ack,
  input  logic             refill,
  output logic             eject10,
  output logic             eject5,
  output logic             eject1,
  output logic             busy,
  output logic             done,
  output logic [7:0]       shortfall,
  output logic             overrun,
  output logic             fault,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv1
);
  typedef enum logic [1:0] {IDLE, SELECT, EJECT, FAULT} state_t;

  localparam logic [INV_W-1:0] L_INIT10 = INV_W'(INV_INIT10);
  localparam logic [INV_W-1:0] L_INIT5  = INV_W'(INV_INIT5);
  localparam logic [INV_W-1:0] L_INIT1  = INV_W'(INV_INIT1);
  localparam logic [INV_W-1:0] L_ONE    = INV_W'(1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_rem, w_rem_nxt;
  logic [15:0]      r_tcnt, w_tcnt_nxt;
  logic             r_ej10, r_ej5, r_ej1, w_ej10_nxt, w_ej5_nxt, w_ej1_nxt;
  logic             r_busy, r_done, r_over, r_fault;
  logic             w_busy_nxt, w_done_nxt, w_over_nxt, w_fault_nxt;
  logic [7:0]       r_short, w_short_nxt;
  logic [INV_W-1:0] r_inv10, r_inv5, r_inv1, w_inv10_nxt, w_inv5_nxt, w_inv1_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_tcnt  <= '0;
      r_ej10  <= 1'b0;
      r_ej5   <= 1'b0;
      r_ej1   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_short <= '0;
      r_over  <= 1'b0;
      r_fault <= 1'b0;
      r_inv10 <= L_INIT10;
      r_inv5  <= L_INIT5;
      r_inv1  <= L_INIT1;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_ej10  <= w_ej10_nxt;
      r_ej5   <= w_ej5_nxt;
      r_ej1   <= w_ej1_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_short <= w_short_nxt;
      r_over  <= w_over_nxt;
      r_fault <= w_fault_nxt;
      r_inv10 <= w_inv10_nxt;
      r_inv5  <= w_inv5_nxt;
      r_inv1  <= w_inv1_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_tcnt_nxt  = r_tcnt;
    w_ej10_nxt  = r_ej10;
    w_ej5_nxt   = r_ej5;
    w_ej1_nxt   = r_ej1;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_short_nxt = r_short;
    w_over_nxt  = r_over;
    w_fault_nxt = r_fault;
    w_inv10_nxt = r_inv10;
    w_inv5_nxt  = r_inv5;
    w_inv1_nxt  = r_inv1;

    if (dispense && r_state != IDLE) w_over_nxt = 1'b1;

    case (r_state)
      IDLE: begin
        if (dispense) begin
          w_rem_nxt   = change;
          w_short_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SELECT;
        end else if (refill) begin
          w_inv10_nxt = L_INIT10;
          w_inv5_nxt  = L_INIT5;
          w_inv1_nxt  = L_INIT1;
        end
      end
      SELECT: begin
        w_tcnt_nxt = '0;
        if (r_rem == 8'd0) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_rem >= 8'd10 && r_inv10 != '0) begin
          w_ej10_nxt  = 1'b1;
          w_state_nxt = EJECT;
        end else if (r_rem >= 8'd5 && r_inv5 != '0) begin
          w_ej5_nxt   = 1'b1;
          w_state_nxt = EJECT;
        end else if (r_inv1 != '0) begin
          w_ej1_nxt   = 1'b1;
          w_state_nxt = EJECT;
        end else begin
          // Nothing left that fits: report what we could not pay.
          w_short_nxt = r_rem;
          w_rem_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      EJECT: begin
        // Ack is tested first so it wins over a same-cycle timeout.
        if (hop_ack) begin
          w_ej10_nxt  = 1'b0;
          w_ej5_nxt   = 1'b0;
          w_ej1_nxt   = 1'b0;
          w_state_nxt = SELECT;
          if (r_ej10) begin
            w_rem_nxt   = r_rem - 8'd10;
            w_inv10_nxt = r_inv10 - L_ONE;
          end else if (r_ej5) begin
            w_rem_nxt   = r_rem - 8'd5;
            w_inv5_nxt  = r_inv5 - L_ONE;
          end else begin
            w_rem_nxt   = r_rem - 8'd1;
            w_inv1_nxt  = r_inv1 - L_ONE;
          end
        end else if (r_tcnt == TO_LAST) begin
          w_ej10_nxt  = 1'b0;
          w_ej5_nxt   = 1'b0;
          w_ej1_nxt   = 1'b0;
          w_fault_nxt = 1'b1;
          w_state_nxt = FAULT;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end
      default: ; // FAULT: parked, busy held, until reset
    endcase
  end

  assign eject10   = r_ej10;
  assign eject5    = r_ej5;
  assign eject1    = r_ej1;
  assign busy      = r_busy;
  assign done      = r_done;
  assign shortfall = r_short;
  assign overrun   = r_over;
  assign fault     = r_fault;
  assign inv10     = r_inv10;
  assign inv5      = r_inv5;
  assign inv1      = r_inv1;
endmodule
